// File: rtl/ncl_pkg.sv
// Shared NCL dual-rail helpers and bridge types.
// Rail pair [1]=true, [0]=false; 2'b00 is NULL.
package ncl_pkg;

  localparam logic [1:0] NCL_NULL = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    NULL
  } state_t;

  typedef struct packed {
    logic neg;
    logic zero;
    logic of;
    logic err;
  } rsp_flags_t;

  function automatic logic [1:0] dr_encode(input logic b);
    return {b, ~b};
  endfunction

  function automatic logic dr_is_data(input logic [1:0] p);
    return p[1] ^ p[0];
  endfunction

  function automatic logic dr_is_null(input logic [1:0] p);
    return p == NCL_NULL;
  endfunction

  function automatic logic dr_is_illegal(input logic [1:0] p);
    return &p;
  endfunction

endpackage

// File: rtl/ncl_completion_sync.sv
// NCL completion detectors for result + flags,
// brought into clk through a SYNC_STAGES flop chain.
module ncl_completion_sync
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] res,
  input  logic [1:0]         neg,
  input  logic [1:0]         zero,
  input  logic [1:0]         of,
  output logic               data_done,
  output logic               null_done,
  output logic               illegal,
  output logic               full
);

  localparam int NP = WIDTH + 3;

  logic [2*NP-1:0] pairs;
  logic [3:0]      raw;
  logic [SYNC_STAGES-1:0][3:0] sh;

  assign pairs = {of, zero, neg, res};

  // full: no pair left NULL (data or illegal everywhere)
  always_comb begin
    logic d_all;
    logic n_all;
    logic ill;
    logic f_all;
    d_all = 1'b1;
    n_all = 1'b1;
    ill   = 1'b0;
    f_all = 1'b1;
    for (int i = 0; i < NP; i++) begin
      d_all = d_all & dr_is_data(pairs[2*i +: 2]);
      n_all = n_all & dr_is_null(pairs[2*i +: 2]);
      ill   = ill | dr_is_illegal(pairs[2*i +: 2]);
      f_all = f_all & ~dr_is_null(pairs[2*i +: 2]);
    end
    raw = {f_all, ill, n_all, d_all};
  end

  // shift all detectors together so they stay mutually consistent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else begin
      sh <= {sh[SYNC_STAGES-2:0], raw};
    end
  end

  assign {full, illegal, null_done, data_done} = sh[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_ula_bridge.sv
// Clocked valid/ready to dual-rail NCL ULA bridge.
// Optional watchdog: define NCL_ULA_TIMEOUT_EN.
module ncl_ula_bridge
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               req_sub,
  output logic [2*WIDTH-1:0] ula_a,
  output logic [2*WIDTH-1:0] ula_b,
  output logic [1:0]         ula_opr,
  input  logic [2*WIDTH-1:0] ula_res,
  input  logic [1:0]         ula_neg,
  input  logic [1:0]         ula_zero,
  input  logic [1:0]         ula_of,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_res,
  output logic               rsp_neg,
  output logic               rsp_zero,
  output logic               rsp_of,
  output logic               rsp_err
);

  state_t state;
  state_t state_nx;

  logic data_s;
  logic null_s;
  logic ill_s;
  logic full_s;
  logic done_s;
  logic rsp_free;
  logic accept;
  logic capture;
  logic tmo_cap;
  logic tmo_hit;

  logic [2*WIDTH-1:0] enc_a;
  logic [2*WIDTH-1:0] enc_b;
  logic [WIDTH-1:0]   dec_res;
  rsp_flags_t         flags_q;

  ncl_completion_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .res       (ula_res),
    .neg       (ula_neg),
    .zero      (ula_zero),
    .of        (ula_of),
    .data_done (data_s),
    .null_done (null_s),
    .illegal   (ill_s),
    .full      (full_s)
  );

  // an 11 pair still ends the wavefront so it can be reported
  assign done_s   = data_s | (ill_s & full_s);
  assign rsp_free = ~rsp_valid | rsp_ready;

  // single-rail to dual-rail encode, true-rail decode
  always_comb begin
    enc_a   = '0;
    enc_b   = '0;
    dec_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      enc_a[2*i +: 2] = dr_encode(req_a[i]);
      enc_b[2*i +: 2] = dr_encode(req_b[i]);
      dec_res[i]      = ula_res[2*i+1];
    end
  end

`ifdef NCL_ULA_TIMEOUT_EN
  localparam int TB = $clog2(TIMEOUT_CYC + 1);
  localparam int TW = (TB > 8) ? TB : 8;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt >= TMO_LIM);

  // per-phase watchdog, restarts on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state_nx != state) begin
      tmo_cnt <= '0;
    end else if (state != IDLE && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and handshake strobes
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    tmo_cap   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (done_s && rsp_free) begin
          capture  = 1'b1;
          state_nx = NULL;
        end else if (tmo_hit && rsp_free) begin
          tmo_cap  = 1'b1;
          state_nx = NULL;
        end
      end
      NULL: begin
        if (null_s || tmo_hit) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ULA drive: DATA wavefront on accept, NULL after capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ula_a   <= '0;
      ula_b   <= '0;
      ula_opr <= NCL_NULL;
    end else if (accept) begin
      ula_a   <= enc_a;
      ula_b   <= enc_b;
      ula_opr <= dr_encode(req_sub);
    end else if (capture || tmo_cap) begin
      ula_a   <= '0;
      ula_b   <= '0;
      ula_opr <= NCL_NULL;
    end
  end

  // response register; a capture overrides a same-cycle consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      flags_q   <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_res   <= dec_res;
      flags_q   <= '{neg:  ula_neg[1],
                     zero: ula_zero[1],
                     of:   ula_of[1],
                     err:  ill_s};
    end else if (tmo_cap) begin
      rsp_valid <= 1'b1;
      rsp_res   <= '0;
      flags_q   <= '{neg: 1'b0, zero: 1'b0,
                     of: 1'b0, err: 1'b1};
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_neg  = flags_q.neg;
  assign rsp_zero = flags_q.zero;
  assign rsp_of   = flags_q.of;
  assign rsp_err  = flags_q.err;

endmodule

// File: tb/tb_ncl_ula_bridge.sv
// Self-checking bench for ncl_ula_bridge with a
// behavioural dual-rail ULA of random phase delay.
module tb_ncl_ula_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_a = '0;
  logic [7:0]  req_b = '0;
  logic        req_sub = 1'b0;
  logic [15:0] ula_a;
  logic [15:0] ula_b;
  logic [1:0]  ula_opr;
  logic [15:0] ula_res = '0;
  logic [1:0]  ula_neg = '0;
  logic [1:0]  ula_zero = '0;
  logic [1:0]  ula_of = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_res;
  logic        rsp_neg;
  logic        rsp_zero;
  logic        rsp_of;
  logic        rsp_err;

  int n_run  = 0;
  int n_fail = 0;
  bit mode_illegal = 0;
  bit mode_stuck   = 0;

  ncl_ula_bridge #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_opr   (ula_opr),
    .ula_res   (ula_res),
    .ula_neg   (ula_neg),
    .ula_zero  (ula_zero),
    .ula_of    (ula_of),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_neg   (rsp_neg),
    .rsp_zero  (rsp_zero),
    .rsp_of    (rsp_of),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dr_vec(input logic [7:0] v);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[2*i+1] = v[i];
      o[2*i]   = ~v[i];
    end
    return o;
  endfunction

  function automatic logic [7:0] tr_vec(input logic [15:0] v);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) o[i] = v[2*i+1];
    return o;
  endfunction

  // two's complement arithmetic reference
  task automatic ref_alu(input logic [7:0] a, input logic [7:0] b,
                         input logic sub, output logic [7:0] r,
                         output logic n, output logic z,
                         output logic o);
    int sa;
    int sb;
    int s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sub ? sa - sb : sa + sb;
    r  = s[7:0];
    n  = r[7];
    z  = (r == 8'h00);
    o  = (s > 127) || (s < -128);
  endtask

  // behavioural ULA: DATA after random delay, NULL after random delay
  initial begin
    logic [7:0] ma;
    logic [7:0] mb;
    logic       ms;
    logic [7:0] r;
    logic       n;
    logic       z;
    logic       o;
    int         d;
    bit         st;
    bit         il;
    forever begin
      @(negedge clk);
      if (ula_opr != 2'b00) begin
        ma = tr_vec(ula_a);
        mb = tr_vec(ula_b);
        ms = ula_opr[1];
        st = mode_stuck;
        il = mode_illegal;
        d  = $urandom_range(0, 20);
        repeat (d) @(negedge clk);
        if (!st) begin
          ref_alu(ma, mb, ms, r, n, z, o);
          ula_res  = dr_vec(r);
          ula_neg  = {n, ~n};
          ula_zero = il ? 2'b11 : {z, ~z};
          ula_of   = {o, ~o};
        end
        while (ula_opr != 2'b00) @(negedge clk);
        d = $urandom_range(0, 20);
        repeat (d) @(negedge clk);
        ula_res  = '0;
        ula_neg  = '0;
        ula_zero = '0;
        ula_of   = '0;
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [7:0] a, input logic [7:0] b,
                        input logic sub);
    int t;
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_run++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL accept: req_ready=%0b after %0d cycles, need 1",
               req_ready, t);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_run++;
    if (ula_a !== dr_vec(a) || ula_b !== dr_vec(b)) begin
      n_fail++;
      $display("FAIL ula_ab: got %h/%h need %h/%h",
               ula_a, ula_b, dr_vec(a), dr_vec(b));
    end
    n_run++;
    if (ula_opr !== {sub, ~sub}) begin
      n_fail++;
      $display("FAIL ula_opr: got %b need %b", ula_opr, {sub, ~sub});
    end
  endtask

  task automatic get_rsp(input int bound, output logic [7:0] r,
                         output logic n, output logic z,
                         output logic o, output logic e);
    int t;
    rsp_ready = 1'b1;
    t = 0;
    while (!rsp_valid && t < bound) begin
      @(negedge clk);
      t++;
    end
    r = rsp_res;
    n = rsp_neg;
    z = rsp_zero;
    o = rsp_of;
    e = rsp_err;
    n_run++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles, need 1", t);
      r = 'x;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic chk_rsp(input string nm, input logic [7:0] a,
                         input logic [7:0] b, input logic sub,
                         input logic exp_err);
    logic [7:0] er;
    logic en;
    logic ez;
    logic eo;
    logic [7:0] r;
    logic n;
    logic z;
    logic o;
    logic e;
    ref_alu(a, b, sub, er, en, ez, eo);
    get_rsp(200, r, n, z, o, e);
    n_run++;
    if ({r, n, z, o, e} !== {er, en, ez, eo, exp_err}) begin
      n_fail++;
      $display("FAIL %s: res/n/z/o/err got %h/%b%b%b%b need %h/%b%b%b%b",
               nm, r, n, z, o, e, er, en, ez, eo, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_run++;
    if ({ula_a, ula_b, ula_opr} !== '0) begin
      n_fail++;
      $display("FAIL reset_ula: got %h %h %b need 0",
               ula_a, ula_b, ula_opr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b need 1", req_ready);
    end
    n_run++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b need 0", rsp_valid);
    end
    n_run++;
    if ({rsp_res, rsp_neg, rsp_zero, rsp_of, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h %b%b%b%b need 0",
               rsp_res, rsp_neg, rsp_zero, rsp_of, rsp_err);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h05, 8'h03, 8'h7F, 8'h42};
    logic [7:0] tb [4] = '{8'h03, 8'h05, 8'h01, 8'h42};
    logic       ts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] xr [4] = '{8'h08, 8'hFE, 8'h80, 8'h00};
    logic       xn [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       xz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       xo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] r;
    logic n;
    logic z;
    logic o;
    logic e;
    for (int i = 0; i < 4; i++) begin
      do_req(ta[i], tb[i], ts[i]);
      get_rsp(200, r, n, z, o, e);
      n_run++;
      if ({r, n, z, o, e} !== {xr[i], xn[i], xz[i], xo[i], 1'b0}) begin
        n_fail++;
        $display("FAIL directed%0d: got %h/%b%b%b%b need %h/%b%b%b0",
                 i, r, n, z, o, e, xr[i], xn[i], xz[i], xo[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      do_req(a, b, s);
      chk_rsp("random", a, b, s, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1;
    logic [7:0] b1;
    logic [7:0] a2;
    logic [7:0] b2;
    logic [7:0] er;
    logic en;
    logic ez;
    logic eo;
    int t;
    int bad;
    a1 = 8'($urandom);
    b1 = 8'($urandom);
    a2 = 8'($urandom);
    b2 = 8'($urandom);
    ref_alu(a1, b1, 1'b1, er, en, ez, eo);
    rsp_ready = 1'b0;
    do_req(a1, b1, 1'b1);
    t = 0;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    do_req(a2, b2, 1'b0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_res !== er) bad++;
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold: %0d bad cycles (rdy=%b val=%b res=%h) need 0 (res %h)",
               bad, req_ready, rsp_valid, rsp_res, er);
    end
    chk_rsp("b2b_first", a1, b1, 1'b1, 1'b0);
    chk_rsp("b2b_second", a2, b2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    do_req(8'h11, 8'h22, 1'b0);
    t = 0;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    do_req(8'h33, 8'h44, 1'b1);
    rst = 1'b1;
    #1;
    n_run++;
    if ({ula_a, ula_b, ula_opr} !== '0) begin
      n_fail++;
      $display("FAIL midrst_ula: got %h %h %b need 0",
               ula_a, ula_b, ula_opr);
    end
    n_run++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_valid: got %b need 0", rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b need 1", req_ready);
    end
    repeat (60) @(negedge clk);
    n_run++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_discard: rsp_valid %b need 0", rsp_valid);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] r;
    logic n;
    logic z;
    logic o;
    logic e;
    logic [7:0] er;
    logic en;
    logic ez;
    logic eo;
    ref_alu(8'h5A, 8'h21, 1'b0, er, en, ez, eo);
    mode_illegal = 1'b1;
    do_req(8'h5A, 8'h21, 1'b0);
    get_rsp(200, r, n, z, o, e);
    mode_illegal = 1'b0;
    n_run++;
    if (e !== 1'b1 || r !== er) begin
      n_fail++;
      $display("FAIL illegal: err/res got %b/%h need 1/%h", e, r, er);
    end
    do_req(8'h10, 8'h01, 1'b1);
    chk_rsp("after_illegal", 8'h10, 8'h01, 1'b1, 1'b0);
  endtask

`ifdef NCL_ULA_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] r;
    logic n;
    logic z;
    logic o;
    logic e;
    mode_stuck = 1'b1;
    do_req(8'h12, 8'h34, 1'b0);
    mode_stuck = 1'b0;
    get_rsp(400, r, n, z, o, e);
    n_run++;
    if (e !== 1'b1 || r !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout: err/res got %b/%h need 1/00", e, r);
    end
    repeat (60) @(negedge clk);
    do_req(8'h01, 8'h01, 1'b0);
    chk_rsp("after_timeout", 8'h01, 8'h01, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
`ifdef NCL_ULA_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
